// File: rtl/collider_pkg.sv
// Shared parameters, FSM state encoding, neighbour offset table and tower indexing
// for the calorimeter tower store and its consumers.
package collider_pkg;

    localparam int N_ETA = 8;
    localparam int N_PHI = 8;
    localparam int ETA_W = 3;
    localparam int PHI_W = 3;
    localparam int ET_W  = 11;
    localparam int SUM_W = ET_W + 4;
    localparam int CNT_W = 7;
    localparam int IDX_W = ETA_W + PHI_W;

    localparam logic [ET_W-1:0] THRESH = ET_W'(20);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_C,
        ST_CK_C,
        ST_RD_N,
        ST_CK_N,
        ST_EMIT,
        ST_DONE
    } state_e;

    localparam logic signed [1:0] OFF_M1 = -2'sd1;
    localparam logic signed [1:0] OFF_Z0 = 2'sd0;
    localparam logic signed [1:0] OFF_P1 = 2'sd1;

    typedef struct packed {
        logic signed [1:0] dphi;
        logic signed [1:0] deta;
    } nbr_off_t;

    // Neighbour visiting order: phi row below, own row (left, right), phi row above.
    function automatic nbr_off_t nbr_off(input logic [2:0] k);
        case (k)
            3'd0:    return '{dphi: OFF_M1, deta: OFF_M1};
            3'd1:    return '{dphi: OFF_M1, deta: OFF_Z0};
            3'd2:    return '{dphi: OFF_M1, deta: OFF_P1};
            3'd3:    return '{dphi: OFF_Z0, deta: OFF_M1};
            3'd4:    return '{dphi: OFF_Z0, deta: OFF_P1};
            3'd5:    return '{dphi: OFF_P1, deta: OFF_M1};
            3'd6:    return '{dphi: OFF_P1, deta: OFF_Z0};
            default: return '{dphi: OFF_P1, deta: OFF_P1};
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] tower_idx(input logic [ETA_W-1:0] eta,
                                                   input logic [PHI_W-1:0] phi);
        return IDX_W'(eta) + IDX_W'(phi) * IDX_W'(N_ETA);
    endfunction

endpackage

// File: rtl/tower_nbr_addr.sv
// Maps a centre tower and neighbour slot to the neighbour's address, with phi
// wrapping around the cylinder and eta edges flagged as out of range.
module tower_nbr_addr
    import collider_pkg::*;
(
    input  logic [ETA_W-1:0] c_eta_i,
    input  logic [PHI_W-1:0] c_phi_i,
    input  logic [2:0]       k_i,
    output logic [ETA_W-1:0] n_eta_o,
    output logic [PHI_W-1:0] n_phi_o,
    output logic             in_range_o,
    output logic             strict_o
);

    nbr_off_t off;

    always_comb begin
        off        = nbr_off(k_i);
        n_eta_o    = c_eta_i;
        n_phi_o    = c_phi_i;
        in_range_o = 1'b1;

        case (off.deta)
            OFF_M1: begin
                in_range_o = (c_eta_i != '0);
                n_eta_o    = c_eta_i - ETA_W'(1);
            end
            OFF_P1: begin
                in_range_o = (c_eta_i != ETA_W'(N_ETA - 1));
                n_eta_o    = c_eta_i + ETA_W'(1);
            end
            default: ;
        endcase

        case (off.dphi)
            OFF_M1:  n_phi_o = (c_phi_i == '0) ? PHI_W'(N_PHI - 1) : c_phi_i - PHI_W'(1);
            OFF_P1:  n_phi_o = (c_phi_i == PHI_W'(N_PHI - 1)) ? '0 : c_phi_i + PHI_W'(1);
            default: ;
        endcase

        // Earlier-scanned neighbours must be strictly lower so a tie keeps only one seed.
        strict_o = (off.dphi == OFF_M1) || ((off.dphi == OFF_Z0) && (off.deta == OFF_M1));
    end

endmodule

// File: rtl/tower_peak_finder.sv
// Scans the tower store for 3x3 local ET maxima above threshold and emits each
// one with its 3x3 sum over a valid/ready handshake.
module tower_peak_finder
    import collider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [ETA_W-1:0] rd_eta,
    output logic [PHI_W-1:0] rd_phi,
    input  logic [ET_W-1:0]  rd_et,
    output logic             cand_valid,
    input  logic             cand_ready,
    output logic [ETA_W-1:0] cand_eta,
    output logic [PHI_W-1:0] cand_phi,
    output logic [ET_W-1:0]  cand_et,
    output logic [SUM_W-1:0] cand_sum,
    output logic [CNT_W-1:0] cand_count
);

    state_e             state_q, state_d;
    logic [ETA_W-1:0]   eta_q, eta_d;
    logic [PHI_W-1:0]   phi_q, phi_d;
    logic [2:0]         k_q, k_d;
    logic [ET_W-1:0]    cand_et_q, cand_et_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               flag_q, flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ETA_W-1:0]   rd_eta_q, rd_eta_d;
    logic [PHI_W-1:0]   rd_phi_q, rd_phi_d;

    logic [ETA_W-1:0]   nb_eta;
    logic [PHI_W-1:0]   nb_phi;
    logic               nb_in_range;
    logic               nb_strict;
    logic [ET_W-1:0]    nbr_val;
    logic               nbr_fail;
    logic               last_tower;
    logic               advance;
    logic [ETA_W-1:0]   next_eta;
    logic [PHI_W-1:0]   next_phi;
    logic [ETA_W-1:0]   addr_eta;
    logic [PHI_W-1:0]   addr_phi;

    tower_nbr_addr u_nbr_addr (
        .c_eta_i    (eta_q),
        .c_phi_i    (phi_q),
        .k_i        (k_q),
        .n_eta_o    (nb_eta),
        .n_phi_o    (nb_phi),
        .in_range_o (nb_in_range),
        .strict_o   (nb_strict)
    );

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign cand_valid = (state_q == ST_EMIT);
    assign rd_en      = (state_q == ST_RD_C) || ((state_q == ST_RD_N) && nb_in_range);
    assign addr_eta   = (state_q == ST_RD_C) ? eta_q : nb_eta;
    assign addr_phi   = (state_q == ST_RD_C) ? phi_q : nb_phi;
    assign rd_eta     = rd_en ? addr_eta : rd_eta_q;
    assign rd_phi     = rd_en ? addr_phi : rd_phi_q;
    assign cand_eta   = eta_q;
    assign cand_phi   = phi_q;
    assign cand_et    = cand_et_q;
    assign cand_sum   = sum_q;
    assign cand_count = cnt_q;

    assign nbr_val    = nb_in_range ? rd_et : '0;
    assign nbr_fail   = nb_strict ? (nbr_val >= cand_et_q) : (nbr_val > cand_et_q);
    assign last_tower = (tower_idx(eta_q, phi_q) == IDX_W'(N_ETA * N_PHI - 1));
    assign next_eta   = (eta_q == ETA_W'(N_ETA - 1)) ? '0 : eta_q + ETA_W'(1);
    assign next_phi   = (eta_q == ETA_W'(N_ETA - 1)) ? phi_q + PHI_W'(1) : phi_q;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path infers a latch.
        state_d   = state_q;
        eta_d     = eta_q;
        phi_d     = phi_q;
        k_d       = k_q;
        cand_et_d = cand_et_q;
        sum_d     = sum_q;
        flag_d    = flag_q;
        cnt_d     = cnt_q;
        rd_eta_d  = rd_en ? addr_eta : rd_eta_q;
        rd_phi_d  = rd_en ? addr_phi : rd_phi_q;
        advance   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD_C;
                    eta_d   = '0;
                    phi_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_RD_C: state_d = ST_CK_C;
            ST_CK_C: begin
                if (rd_et < THRESH) begin
                    advance = 1'b1;
                end else begin
                    cand_et_d = rd_et;
                    sum_d     = SUM_W'(rd_et);
                    flag_d    = 1'b1;
                    k_d       = '0;
                    state_d   = ST_RD_N;
                end
            end
            ST_RD_N: state_d = ST_CK_N;
            ST_CK_N: begin
                sum_d = sum_q + SUM_W'(nbr_val);
                if (nbr_fail) flag_d = 1'b0;
                if (k_q == 3'd7) begin
                    if (flag_d) state_d = ST_EMIT;
                    else        advance = 1'b1;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = ST_RD_N;
                end
            end
            ST_EMIT: begin
                if (cand_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    advance = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (last_tower) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_RD_C;
                eta_d   = next_eta;
                phi_d   = next_phi;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            eta_q     <= '0;
            phi_q     <= '0;
            k_q       <= '0;
            cand_et_q <= '0;
            sum_q     <= '0;
            flag_q    <= 1'b0;
            cnt_q     <= '0;
            rd_eta_q  <= '0;
            rd_phi_q  <= '0;
        end else begin
            state_q   <= state_d;
            eta_q     <= eta_d;
            phi_q     <= phi_d;
            k_q       <= k_d;
            cand_et_q <= cand_et_d;
            sum_q     <= sum_d;
            flag_q    <= flag_d;
            cnt_q     <= cnt_d;
            rd_eta_q  <= rd_eta_d;
            rd_phi_q  <= rd_phi_d;
        end
    end

endmodule

// File: tb/tb_tower_peak_finder.sv
// Directed bench for tower_peak_finder: table of grids with hand-computed
// candidates and timing, plus backpressure and mid-scan reset sequences.
module tb_tower_peak_finder;
    import collider_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [ETA_W-1:0] rd_eta;
    logic [PHI_W-1:0] rd_phi;
    logic [ET_W-1:0]  rd_et = '1;
    logic             cand_valid;
    logic             cand_ready;
    logic [ETA_W-1:0] cand_eta;
    logic [PHI_W-1:0] cand_phi;
    logic [ET_W-1:0]  cand_et;
    logic [SUM_W-1:0] cand_sum;
    logic [CNT_W-1:0] cand_count;

    tower_peak_finder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_eta     (rd_eta),
        .rd_phi     (rd_phi),
        .rd_et      (rd_et),
        .cand_valid (cand_valid),
        .cand_ready (cand_ready),
        .cand_eta   (cand_eta),
        .cand_phi   (cand_phi),
        .cand_et    (cand_et),
        .cand_sum   (cand_sum),
        .cand_count (cand_count)
    );

    always #5 clk = ~clk;

    // Tower store model: one-cycle read latency, junk on cycles without a read.
    logic [ET_W-1:0] mem [N_ETA*N_PHI];
    always @(posedge clk) rd_et <= rd_en ? mem[int'(rd_eta) + int'(rd_phi) * N_ETA] : '1;

    logic [48:0] all_out;
    assign all_out = {busy, done, rd_en, cand_valid, cand_count, rd_eta, rd_phi,
                      cand_eta, cand_phi, cand_et, cand_sum};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int e0, p0, v0, e1, p1, v1, e2, p2, v2;
        int ncand, c_eta, c_phi, c_et, c_sum, done_cyc, rd_cnt;
    } vec_t;

    vec_t vecs [7];

    int r_done, r_rd, r_ncand, r_eta, r_phi, r_et, r_sum, r_busy1, r_busy_done;

    task automatic load_grid(input vec_t v);
        for (int i = 0; i < N_ETA * N_PHI; i++) mem[i] = '0;
        if (v.v0 != 0) mem[v.e0 + v.p0 * N_ETA] = ET_W'(v.v0);
        if (v.v1 != 0) mem[v.e1 + v.p1 * N_ETA] = ET_W'(v.v1);
        if (v.v2 != 0) mem[v.e2 + v.p2 * N_ETA] = ET_W'(v.v2);
    endtask

    // Cycle n is the clock period after edge n-1; start is sampled at edge 0.
    task automatic run_scan;
        int cyc;
        r_done = -1; r_rd = 0; r_ncand = 0;
        r_eta = -1; r_phi = -1; r_et = -1; r_sum = -1;
        r_busy1 = -1; r_busy_done = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        while (cyc < 3000) begin
            @(negedge clk);
            if (cyc == 1) r_busy1 = int'(busy);
            if (cyc == 4) start = 1'b0;
            if (rd_en) r_rd++;
            if (cand_valid && cand_ready) begin
                if (r_ncand == 0) begin
                    r_eta = int'(cand_eta); r_phi = int'(cand_phi);
                    r_et  = int'(cand_et);  r_sum = int'(cand_sum);
                end
                r_ncand++;
            end
            if (done) begin
                r_done = cyc;
                r_busy_done = int'(busy);
                break;
            end
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_scan(input string tag, input vec_t v);
        check({tag, "_done_cycle"}, r_done, v.done_cyc);
        check({tag, "_rd_count"}, r_rd, v.rd_cnt);
        check({tag, "_ncand"}, r_ncand, v.ncand);
        check({tag, "_cand_eta"}, r_eta, v.c_eta);
        check({tag, "_cand_phi"}, r_phi, v.c_phi);
        check({tag, "_cand_et"}, r_et, v.c_et);
        check({tag, "_cand_sum"}, r_sum, v.c_sum);
        check({tag, "_busy_cyc1"}, r_busy1, 1);
        check({tag, "_busy_at_done"}, r_busy_done, 0);
        check({tag, "_cand_count"}, cand_count, v.ncand);
    endtask

    initial begin
        int   cyc;
        int   bad;
        int   rd_pre;
        int   first_valid;
        vec_t one;

        //           e0 p0  v0  e1 p1 v1  e2 p2  v2  nc eta phi  et  sum done  rd
        vecs[0] = '{0, 0,   0, 0, 0,  0, 0, 0,   0, 0, -1, -1, -1,  -1, 129, 64};
        vecs[1] = '{3, 4, 100, 0, 0,  0, 0, 0,   0, 1,  3,  4, 100, 100, 146, 72};
        vecs[2] = '{2, 0,  50, 2, 7, 30, 0, 0,   0, 1,  2,  0,  50,  80, 162, 80};
        vecs[3] = '{4, 4,  60, 5, 4, 60, 0, 0,   0, 1,  4,  4,  60, 120, 162, 80};
        vecs[4] = '{1, 1,  19, 6, 3, 20, 0, 0,   0, 1,  6,  3,  20,  20, 146, 72};
        vecs[5] = '{5, 5, 200, 4, 4, 10, 6, 6, 150, 1,  5,  5, 200, 360, 162, 80};
        vecs[6] = '{7, 0,  21, 0, 0,  0, 0, 0,   0, 1,  7,  0,  21,  21, 146, 69};

        rst = 1'b0; start = 1'b0; cand_ready = 1'b0;
        for (int i = 0; i < N_ETA * N_PHI; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_out, 0);
        rst = 1'b1;
        @(negedge clk);

        cand_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            load_grid(vecs[i]);
            run_scan();
            check_scan($sformatf("v%0d", i), vecs[i]);
        end

        // Backpressure on an eta-edge seed at (0,0).
        one = '{0, 0, 25, 0, 0, 0, 0, 0, 0, 1, 0, 0, 25, 25, 156, 69};
        load_grid(one);
        cand_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 1; rd_pre = 0; first_valid = -1;
        while (cyc < 100) begin
            @(negedge clk);
            if (cyc == 2) start = 1'b0;
            if (cand_valid) begin
                first_valid = cyc;
                break;
            end
            if (rd_en) rd_pre++;
            @(posedge clk);
            cyc++;
        end
        check("stall_first_valid_cycle", first_valid, 19);
        check("stall_reads_before_emit", rd_pre, 6);
        check("stall_cand_fields", {cand_eta, cand_phi, cand_et, cand_sum},
              {3'd0, 3'd0, 11'd25, 15'd25});
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!cand_valid || rd_en || cand_eta != 3'd0 || cand_phi != 3'd0 ||
                cand_et != 11'd25 || cand_sum != 15'd25 || cand_count != 7'd0) bad++;
            @(posedge clk);
            @(negedge clk);
        end
        check("stall_hold_violations", bad, 0);
        cyc = 29;
        cand_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 30;
        check("stall_resume_read", {rd_en, rd_eta, rd_phi, cand_valid}, {1'b1, 3'd1, 3'd0, 1'b0});
        check("stall_count_after_xfer", cand_count, 1);
        r_done = -1;
        while (cyc < 400) begin
            if (done) begin
                r_done = cyc;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("stall_done_cycle", r_done, one.done_cyc);

        // Reset during CK_N of the (3,4) seed: CK_C in cycle 72, first CK_N in cycle 74.
        load_grid(vecs[1]);
        cand_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1 start = 1'b0;
        while (cyc < 74) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        check("pre_rst_ckn_busy_rden", {busy, rd_en}, 2'b10);
        rst = 1'b0;
        #1 check("rst_ckn_outputs", all_out, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (all_out != 0) bad++;
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || rd_en) bad++;
        end
        check("rst_ckn_quiet", bad, 0);

        // Reset while parked in EMIT: EMIT first in cycle 89.
        cand_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 1; first_valid = -1;
        while (cyc < 300) begin
            @(negedge clk);
            if (cyc == 2) start = 1'b0;
            if (cand_valid) begin
                first_valid = cyc;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        check("rst_emit_valid_cycle", first_valid, 89);
        #2 rst = 1'b0;
        #1 check("rst_emit_outputs", all_out, 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (all_out != 0) bad++;
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || rd_en) bad++;
        end
        check("rst_emit_quiet", bad, 0);

        cand_ready = 1'b1;
        load_grid(vecs[3]);
        run_scan();
        check_scan("post_rst", vecs[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tower_peak_finder.md
# tower_peak_finder

Downstream consumer of the calorimeter tower store. Once the store is filled, the finder scans every (eta, phi) tower through the store's read port. It finds local ET maxima at or above a threshold in a 3x3 window, with phi treated as cylindrical. Each maximum is emitted as a cluster candidate carrying its 3x3 ET sum over a valid/ready handshake to the trigger logic.

## Interface
- N_ETA, 8, towers in eta
- N_PHI, 8, towers in phi
- ETA_W, 3, eta index width
- PHI_W, 3, phi index width
- ET_W, 11, tower ET width
- THRESH, 20, minimum seed ET (inclusive)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  begin a scan; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at end of scan
- rd_en  output  1  tower read request
- rd_eta  output  ETA_W  read eta index
- rd_phi  output  PHI_W  read phi index
- rd_et  input  ET_W  tower ET, valid the cycle after rd_en
- cand_valid  output  1  candidate available
- cand_ready  input  1  consumer accepts candidate
- cand_eta  output  ETA_W  seed eta
- cand_phi  output  PHI_W  seed phi
- cand_et  output  ET_W  seed ET
- cand_sum  output  ET_W+4  3x3 ET sum
- cand_count  output  7  candidates emitted this scan

## Operation
- Scan order: phi outer and eta inner, 0..N_PHI-1 / 0..N_ETA-1, i.e. the linear index eta + phi*N_ETA ascending.
- States:
  - IDLE: start goes to RD_C at tower (0,0) and clears cand_count.
  - RD_C: issues the centre read.
  - CK_C: captures rd_et.
    - If the value is below THRESH, go to the next tower, or to DONE after the last tower.
    - Otherwise latch the centre, set sum = centre, and go to RD_N with k=0.
  - RD_N / CK_N: alternate for neighbour k = 0..7 in this fixed (dphi, deta) order: (-1,-1) (-1,0) (-1,+1) (0,-1) (0,+1) (+1,-1) (+1,0) (+1,+1).
  - EMIT: holds the candidate.
  - DONE: pulses done and returns to IDLE.
- Neighbour phi wraps modulo N_PHI.
- An eta neighbour outside 0..N_ETA-1 still spends its RD_N/CK_N slot. rd_en stays low for that slot and the neighbour is taken as ET 0.
- Local-max rule:
  - Neighbours with dphi<0, or with dphi=0 and deta<0, must be strictly less than the centre.
  - All other neighbours must be less than or equal to the centre.
  - Any failure clears the candidate flag. All 8 slots are still spent, with no early abort.
- Sum: centre plus all in-range neighbours, unsigned, ET_W+4 bits, never overflows.
- After CK_N k=7:
  - If the candidate flag is set, go to EMIT.
  - Otherwise go to the next tower.
- EMIT:
  - cand_valid is high and the cand_* fields are stable until cand_valid and cand_ready are both high.
  - On that transfer cycle, cand_count increments and the FSM proceeds to the next tower, or to DONE.
  - No reads are issued while in EMIT.
- start while busy is ignored.
- rd_eta and rd_phi hold their last value when rd_en is low.

## Timing
- Reset (rst low, asynchronous): state IDLE. All outputs are 0, including busy, done, rd_en, cand_valid, cand_count, rd_eta, rd_phi, cand_eta, cand_phi, cand_et and cand_sum.
- Reset mid-scan aborts the scan immediately. No done pulse is produced.
- Read latency is fixed at 1: rd_en in cycle t, rd_et captured at the edge ending cycle t+1.
- Per-tower cost:
  - Centre below THRESH: 2 cycles.
  - Rejected seed: 18 cycles.
  - Accepted seed: 18 cycles + 1 EMIT cycle when cand_ready is high, plus any backpressure cycles.
- With start sampled at edge 0:
  - First rd_en is in cycle 1.
  - For a grid with no seed, done is high in cycle 2*N_ETA*N_PHI+1 = 129.
- busy falls in the same cycle done is high.

## Structure
- Shared package collider_pkg holds:
  - N_ETA, N_PHI, ETA_W, PHI_W, ET_W;
  - the state enum;
  - the neighbour offset table;
  - a tower-index function, eta + phi*N_ETA.
- One sub-module, tower_nbr_addr: combinational mapping from (centre eta, centre phi, k) to (rd_eta, rd_phi, in_range, strict), with phi wrap and eta edge detection.

## Test plan
- All towers 0, start -> 64 rd_en pulses, no cand_valid, done in cycle 129, cand_count=0.
- Only (eta3,phi4)=100, cand_ready tied high -> one candidate (3,4,100,sum=100), done in cycle 146, cand_count=1.
- (2,0)=50 and (2,7)=30 -> candidate (2,0,50,sum=80) only. (2,7) is rejected through phi wrap, since (2,0) is its (+1,0) neighbour and 50>30.
- (4,4)=60 and (5,4)=60 tie -> only (4,4), sum=120. (5,4) fails the strict test on its (0,-1) neighbour.
- (0,0)=25 with cand_ready held low 10 cycles:
  - candidate (0,0,25,25) is presented;
  - 3 eta-edge slots have rd_en low;
  - cand_* stay stable and no rd_en is issued while stalled;
  - the scan resumes at (1,0) after the handshake.
- Assert rst low during the scan, in CK_N and again in EMIT -> all outputs 0 immediately, no done pulse. A new start then runs a full, correct scan.
